// File: rtl/calc_pkg.sv
// Shared constants for the calculator front-end sequencer: widths, state and op encodings.
package calc_pkg;

  localparam int W_IN  = 5;
  localparam int W_OUT = 8;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/calc_seq_dpath.sv
// Operand/op registers, shift-add accumulator over a single shared adder, and the
// registered result/valid/overflow presented while the controller sits in DONE.
module calc_seq_dpath
  import calc_pkg::*;
#(
  parameter int W_IN  = calc_pkg::W_IN,
  parameter int W_OUT = calc_pkg::W_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  sw_in,
  input  logic             op,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             clr_acc,
  input  logic             step,
  input  logic             load_res,
  input  logic             clr_val,
  output logic             is_last,
  output logic [W_IN-1:0]  a_o,
  output logic [W_IN-1:0]  b_o,
  output logic [W_OUT-1:0] result_o,
  output logic             result_val_o,
  output logic             overflow_o
);

  localparam int W_ACC = 2 * W_IN;
  localparam int W_CNT = (W_IN > 1) ? $clog2(W_IN) : 1;

  logic [W_IN-1:0]  a_q, a_d, b_q, b_d;
  logic             op_q, op_d;
  logic [W_ACC-1:0] acc_q, acc_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [W_OUT-1:0] res_q, res_d;
  logic             val_q, val_d, ovf_q, ovf_d;

  logic [W_ACC-1:0] shifted, add_x, add_y, sum;

  // One adder serves both ops: add presents A and B directly, multiply adds the
  // partial product selected by the current multiplier bit onto the accumulator.
  always_comb begin
    shifted = W_ACC'(a_q) << cnt_q;
    if (op_q == OP_MUL) begin
      add_x = acc_q;
      add_y = b_q[cnt_q] ? shifted : '0;
    end else begin
      add_x = W_ACC'(a_q);
      add_y = W_ACC'(b_q);
    end
    sum     = add_x + add_y;
    is_last = (op_q == OP_ADD) || (cnt_q == W_CNT'(W_IN - 1));
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    val_d = val_q;
    ovf_d = ovf_q;

    if (load_a) a_d = sw_in;
    if (load_b) begin
      b_d  = sw_in;
      op_d = op;
    end

    if (clr_acc) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      acc_d = sum;
      if (!is_last) cnt_d = cnt_q + W_CNT'(1);
    end

    // Result is taken from the adder output so it lands on the edge entering DONE.
    if (load_res) begin
      res_d = sum[W_OUT-1:0];
      val_d = 1'b1;
      ovf_d = |sum[W_ACC-1:W_OUT];
    end else if (clr_val) begin
      val_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_ADD;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      val_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      val_q <= val_d;
      ovf_q <= ovf_d;
    end
  end

  assign a_o          = a_q;
  assign b_o          = b_q;
  assign result_o     = res_q;
  assign result_val_o = val_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator front-end sequencer: collects two operands from one switch bank and
// runs add (1 cycle) or shift-add multiply (W_IN cycles) on the shared datapath.
//
//   state | meaning
//   GET_A | waiting for first operand
//   GET_B | waiting for second operand and op
//   CALC  | datapath iterating, enter ignored
//   DONE  | result valid; enter starts a new operand A
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int W_IN  = calc_pkg::W_IN,
  parameter int W_OUT = calc_pkg::W_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_IN-1:0]  sw_in,
  input  logic             op,
  input  logic             enter,
  input  logic             clear,
  output logic [W_IN-1:0]  in0_out,
  output logic [W_IN-1:0]  in1_out,
  output logic [W_OUT-1:0] result,
  output logic             result_val,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  state_e state_q, state_d;
  logic   rst_all;
  logic   load_a, load_b, clr_acc, step, load_res, clr_val, is_last;

  // Soft clear behaves exactly like reset and beats a simultaneous enter.
  assign rst_all = rst | clear;

  always_ff @(posedge clk) begin
    if (rst_all) state_q <= GET_A;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:   if (enter)   state_d = GET_B;
      GET_B:   if (enter)   state_d = CALC;
      CALC:    if (is_last) state_d = DONE;
      DONE:    if (enter)   state_d = GET_B;
      default:              state_d = GET_A;
    endcase
  end

  always_comb begin
    load_a    = enter && ((state_q == GET_A) || (state_q == DONE));
    load_b    = enter && (state_q == GET_B);
    clr_acc   = load_b;
    step      = (state_q == CALC);
    load_res  = step && is_last;
    clr_val   = enter && (state_q == DONE);
    busy      = (state_q == CALC);
    state_dbg = state_q;
  end

  calc_seq_dpath #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT)
  ) u_dpath (
    .clk          (clk),
    .rst          (rst_all),
    .sw_in        (sw_in),
    .op           (op),
    .load_a       (load_a),
    .load_b       (load_b),
    .clr_acc      (clr_acc),
    .step         (step),
    .load_res     (load_res),
    .clr_val      (clr_val),
    .is_last      (is_last),
    .a_o          (in0_out),
    .b_o          (in1_out),
    .result_o     (result),
    .result_val_o (result_val),
    .overflow_o   (overflow)
  );

endmodule
